mux2_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select of a 2:1 datapath mux and registers the muxed output. Requester 0 drives channel `a` and requester 1 drives channel `b`. The block grants the shared path to one requester at a time, drives `sel`, and presents the selected data one cycle later with a valid flag. It sits between two producers and a single downstream consumer that can take one stream at a time.

---
 rtl/mux2_arbiter.sv | 119 +++++++++++
 tb/tb_mux2_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux, with a registered output stage.
// Optional forced handover after MAX_BURST grant cycles is enabled by defining MUXARB_TIMEOUT_EN.
module mux2_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] z,
    output logic             z_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             last_reg;
    logic             sel_reg;
    logic [WIDTH-1:0] z_reg;
    logic [WIDTH-1:0] z_next;
    logic             z_valid_reg;
    logic             burst_done;

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("mux2_arbiter: MAX_BURST must be >= 1");
    end

`ifdef MUXARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] cnt_reg;
    assign burst_done = (cnt_reg == CNT_W'(MAX_BURST));
`else
    assign burst_done = 1'b0;
`endif

    // Owner keeps the path while it requests, unless its burst is exhausted and the other side waits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1)
                    state_next = last_reg ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_next = req1 ? OWN1 : IDLE;
                else if (burst_done && req1)
                    state_next = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_next = req0 ? OWN0 : IDLE;
                else if (burst_done && req0)
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output capture follows the state at the edge, so z lags sel by exactly one cycle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
        assign z_next[gi] = (state_reg == OWN1) ? b[gi] :
                            (state_reg == OWN0) ? a[gi] : z_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            sel_reg     <= 1'b0;
            z_reg       <= '0;
            z_valid_reg <= 1'b0;
`ifdef MUXARB_TIMEOUT_EN
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            z_reg       <= z_next;
            z_valid_reg <= (state_reg != IDLE);

            if (state_next == OWN0)
                sel_reg <= 1'b0;
            else if (state_next == OWN1)
                sel_reg <= 1'b1;

            if (state_next != state_reg && state_next != IDLE)
                last_reg <= (state_next == OWN1);

`ifdef MUXARB_TIMEOUT_EN
            if (state_next != state_reg && state_next != IDLE)
                cnt_reg <= CNT_W'(1);
            else if (state_next != IDLE && !burst_done)
                cnt_reg <= cnt_reg + CNT_W'(1);
`endif
        end
    end

    assign gnt0    = (state_reg == OWN0);
    assign gnt1    = (state_reg == OWN1);
    assign sel     = sel_reg;
    assign z       = z_reg;
    assign z_valid = z_valid_reg;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, single requester, arbitration, handover, burst limit, mid-burst reset.
// Observed outputs are packed as {gnt0, gnt1, sel, z_valid, z[3:0]}.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [3:0] a;
    logic [3:0] b;
    logic       gnt0;
    logic       gnt1;
    logic       sel;
    logic [3:0] z;
    logic       z_valid;

    int checks = 0;
    int errors = 0;

    wire [7:0] obs = {gnt0, gnt1, sel, z_valid, z};

    mux2_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a       (a),
        .b       (b),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .z       (z),
        .z_valid (z_valid)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; a = 4'h5; b = 4'hA;
        tick();
        checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL reset_cycle1 got %b want %b", obs, 8'b0000_0000); end
        tick();
        checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL reset_cycle2 got %b want %b", obs, 8'b0000_0000); end
        rst_n = 1'b1;
        tick();
        checks++; if (obs !== 8'b1000_0000) begin errors++; $display("FAIL reset_release_gnt0 got %b want %b", obs, 8'b1000_0000); end
        tick();
        checks++; if (obs !== 8'b1001_0101) begin errors++; $display("FAIL reset_first_data got %b want %b", obs, 8'b1001_0101); end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checks++; if (obs !== 8'b0001_0101) begin errors++; $display("FAIL reset_release_last_beat got %b want %b", obs, 8'b0001_0101); end
        tick();
        checks++; if (obs !== 8'b0000_0101) begin errors++; $display("FAIL reset_idle got %b want %b", obs, 8'b0000_0101); end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        req0 = 1'b1; a = 4'h1;
        tick();
        checks++; if (obs !== 8'b1000_0101) begin errors++; $display("FAIL single_grant got %b want %b", obs, 8'b1000_0101); end
        a = 4'h1;
        tick();
        checks++; if (obs !== 8'b1001_0001) begin errors++; $display("FAIL single_beat1 got %b want %b", obs, 8'b1001_0001); end
        a = 4'h0;
        tick();
        checks++; if (obs !== 8'b1001_0000) begin errors++; $display("FAIL single_beat2 got %b want %b", obs, 8'b1001_0000); end
        a = 4'h1; req0 = 1'b0;
        tick();
        checks++; if (obs !== 8'b0001_0001) begin errors++; $display("FAIL single_beat3_on_drop got %b want %b", obs, 8'b0001_0001); end
        tick();
        checks++; if (obs !== 8'b0000_0001) begin errors++; $display("FAIL single_valid_low got %b want %b", obs, 8'b0000_0001); end
        $display("test_single done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_simultaneous();
        a = 4'hC; b = 4'h3; req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++; if (obs !== 8'b0110_0001) begin errors++; $display("FAIL simul_gnt1 got %b want %b", obs, 8'b0110_0001); end
        tick();
        checks++; if (obs !== 8'b0111_0011) begin errors++; $display("FAIL simul_data_b got %b want %b", obs, 8'b0111_0011); end
        req1 = 1'b0;
        tick();
        checks++; if (obs !== 8'b1001_0011) begin errors++; $display("FAIL simul_handover_to0 got %b want %b", obs, 8'b1001_0011); end
        $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_handover();
        a = 4'h9; req1 = 1'b1;
        tick();
        checks++; if (obs !== 8'b1001_1001) begin errors++; $display("FAIL handover_own0_hold got %b want %b", obs, 8'b1001_1001); end
        req0 = 1'b0; a = 4'h6; b = 4'h7;
        tick();
        checks++; if (obs !== 8'b0111_0110) begin errors++; $display("FAIL handover_switch got %b want %b", obs, 8'b0111_0110); end
        tick();
        checks++; if (obs !== 8'b0111_0111) begin errors++; $display("FAIL handover_follow_b got %b want %b", obs, 8'b0111_0111); end
        b = 4'h2; req1 = 1'b0;
        tick();
        checks++; if (obs !== 8'b0011_0010) begin errors++; $display("FAIL handover_last_beat got %b want %b", obs, 8'b0011_0010); end
        tick();
        checks++; if (obs !== 8'b0010_0010) begin errors++; $display("FAIL handover_idle_sel_hold got %b want %b", obs, 8'b0010_0010); end
        $display("test_handover done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_timeout();
        logic       exp_g0;
        logic       prev_g0;
        logic [3:0] exp_z;
        logic [7:0] exp;
        a = 4'h4; b = 4'hB; req0 = 1'b1; req1 = 1'b1;
        prev_g0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
`ifdef MUXARB_TIMEOUT_EN
            exp_g0 = ((i % 8) < 4);
`else
            exp_g0 = 1'b1;
`endif
            exp_z = (i == 0) ? 4'h2 : (prev_g0 ? 4'h4 : 4'hB);
            exp   = {exp_g0, ~exp_g0, ~exp_g0, (i > 0), exp_z};
            tick();
            checks++; if (obs !== exp) begin errors++; $display("FAIL timeout_cycle%0d got %b want %b", i, obs, exp); end
            prev_g0 = exp_g0;
        end
        $display("test_timeout done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_burst();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        req1 = 1'b1; b = 4'h5;
        tick();
        checks++; if (obs[7:5] !== 3'b011) begin errors++; $display("FAIL midrst_own1 got %b want %b", obs[7:5], 3'b011); end
        tick();
        checks++; if (obs !== 8'b0111_0101) begin errors++; $display("FAIL midrst_burst_data got %b want %b", obs, 8'b0111_0101); end
        rst_n = 1'b0; req0 = 1'b1;
        tick();
        checks++; if (obs !== 8'b0000_0000) begin errors++; $display("FAIL midrst_outputs_zero got %b want %b", obs, 8'b0000_0000); end
        rst_n = 1'b1;
        tick();
        checks++; if (obs !== 8'b1000_0000) begin errors++; $display("FAIL midrst_req0_wins got %b want %b", obs, 8'b1000_0000); end
        $display("test_reset_mid_burst done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; a = '0; b = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_handover();
        test_timeout();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
